// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the CPU byte-bus target: I/O window addresses,
// region-select bits and the bus operation decoder.
package ram_io_responder_pkg;

    localparam logic [17:0] IO_BASE     = 18'h30000;
    localparam logic [17:0] IO_UART_OFS = 18'h00000;
    localparam logic [17:0] IO_CLK_OFS  = 18'h00004;

    localparam logic [17:0] IO_UART_ADDR = IO_BASE + IO_UART_OFS;
    localparam logic [17:0] IO_CLK_ADDR  = IO_BASE + IO_CLK_OFS;

    // addr[17:16] == 2'b11 selects the I/O window, anything else is RAM
    localparam int         REGION_HI = 17;
    localparam int         REGION_LO = 16;
    localparam logic [1:0] IO_REGION = 2'b11;

    // One bus operation happens every cycle; there is no idle encoding.
    typedef enum logic [2:0] {
        OP_RAM_RD,
        OP_RAM_WR,
        OP_UART_RD,
        OP_UART_WR,
        OP_CLK_RD,
        OP_STOP_WR,
        OP_IO_NOP
    } bus_op_e;

    // Classify the current bus cycle from the 18 decoded address bits.
    function automatic bus_op_e decode_op(input logic [17:0] addr, input logic wr);
        bus_op_e op;
        if (addr[REGION_HI:REGION_LO] != IO_REGION) begin
            op = wr ? OP_RAM_WR : OP_RAM_RD;
        end else if (addr == IO_UART_ADDR) begin
            op = wr ? OP_UART_WR : OP_UART_RD;
        end else if (!wr && (addr[17:2] == IO_CLK_ADDR[17:2])) begin
            op = OP_CLK_RD;
        end else if (wr && (addr == IO_CLK_ADDR)) begin
            op = OP_STOP_WR;
        end else begin
            op = OP_IO_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO used for the UART TX and RX queues.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored; head byte is
// presented combinationally on dout (no bypass from din).
module ram_io_responder_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Target end of the CPU byte memory bus: block RAM with 1-cycle read
// latency plus the I/O window at 0x30000 (UART byte FIFOs, free-running
// cycle counter with coherent snapshot, sticky program-stop flag).
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
);

    localparam int RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int TX_CW     = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW     = $clog2(RX_DEPTH) + 1;

    // Nearly-full mark leaves room for one write already on its way.
    localparam logic [TX_CW-1:0] TX_FULL_MARK = TX_CW'(TX_DEPTH - 2);

    bus_op_e                 op;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [7:0]              ram [RAM_WORDS];

    logic [7:0]              ram_q_p1;
    logic                    ram_sel_p1;
    logic [7:0]              io_q_p1;
    logic [7:0]              io_rd_data;

    logic [31:0]             cycle_cnt;
    logic [31:0]             snapshot;

    logic                    tx_push;
    logic                    tx_pop;
    logic [7:0]              tx_din;
    logic                    tx_full;
    logic                    tx_empty;
    logic [TX_CW-1:0]        tx_count;

    logic                    rx_pop;
    logic [7:0]              rx_head;
    logic                    rx_full;
    logic                    rx_empty;
    logic [RX_CW-1:0]        rx_count;

    logic                    unused_bits;

    assign op      = decode_op(mem_a[17:0], mem_wr);
    assign ram_idx = mem_a[ADDR_WIDTH-1:0];

    // Only the low 18 address bits and part of the FIFO status are consumed.
    assign unused_bits = ^{mem_a[31:18], tx_full, rx_full, rx_count, snapshot[7:0]};

    localparam int unused_init_file_bits = $bits(INIT_FILE);

    // Block RAM: write-first is not needed, a read always returns old data.
    always_ff @(posedge clk_in) begin
        if (op == OP_RAM_WR) begin
            ram[ram_idx] <= mem_dout;
        end
        ram_q_p1 <= ram[ram_idx];
    end

    // TX queue: zero bytes written by the CPU are filtered out; the stop
    // write injects a single 0x00 terminator.
    assign tx_push  = ((op == OP_UART_WR) && (mem_dout != 8'h00)) ||
                      ((op == OP_STOP_WR) && !program_stop);
    assign tx_din   = (op == OP_STOP_WR) ? 8'h00 : mem_dout;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;

    ram_io_responder_byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (tx_din),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // RX queue: every read of the UART address pops when data is present.
    assign rx_pop = (op == OP_UART_RD);

    ram_io_responder_byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Select the byte an I/O read returns; unmapped reads give zero.
    always_comb begin
        io_rd_data = 8'h00;
        case (op)
            OP_UART_RD: begin
                if (!rx_empty) begin
                    io_rd_data = rx_head;
                end
            end
            OP_CLK_RD: begin
                case (mem_a[1:0])
                    2'd0:    io_rd_data = cycle_cnt[7:0];
                    2'd1:    io_rd_data = snapshot[15:8];
                    2'd2:    io_rd_data = snapshot[23:16];
                    default: io_rd_data = snapshot[31:24];
                endcase
            end
            default: io_rd_data = 8'h00;
        endcase
    end

    // Read-return stage: remember the source so mem_din is valid one cycle later.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ram_sel_p1 <= 1'b0;
            io_q_p1    <= 8'h00;
        end else begin
            ram_sel_p1 <= (op == OP_RAM_RD);
            io_q_p1    <= io_rd_data;
        end
    end

    assign mem_din = ram_sel_p1 ? ram_q_p1 : io_q_p1;

    // Cycle counter, snapshot for coherent dword reads, and the stop flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cycle_cnt    <= 32'd0;
            snapshot     <= 32'd0;
            program_stop <= 1'b0;
        end else begin
            if (!program_stop) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((op == OP_CLK_RD) && (mem_a[1:0] == 2'd0)) begin
                snapshot <= cycle_cnt;
            end
            if (op == OP_STOP_WR) begin
                program_stop <= 1'b1;
            end
        end
    end

    // Registered nearly-full flag toward the CPU.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            io_buffer_full <= 1'b0;
        end else begin
            io_buffer_full <= (tx_count >= TX_FULL_MARK);
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed, table-driven bench for ram_io_responder.
module tb_ram_io_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_stop;

    int n_cmp = 0;
    int n_bad = 0;

    // Clock edges seen since reset was released: what the cycle counter should hold.
    logic [31:0] edges;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic        chk_din;
        logic [7:0]  exp_din;
        logic        chk_tx;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    ram_io_responder dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_stop   (program_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 32'd0;
        else        edges <= edges + 32'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic [7:0] dout,
                                input logic rxv, input logic [7:0] rxd, input logic txr,
                                input logic cd, input logic [7:0] ed,
                                input logic ct, input logic etv, input logic [7:0] etd);
        vec_t v;
        v.a = a; v.wr = wr; v.dout = dout;
        v.rxv = rxv; v.rxd = rxd; v.txr = txr;
        v.chk_din = cd; v.exp_din = ed;
        v.chk_tx = ct; v.exp_txv = etv; v.exp_txd = etd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Present one bus op, clock it, and return 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        logic [31:0] frozen;
        logic [7:0]  b0, b1, b2, b3;
        int          guard;

        rst_n = 1'b0; mem_a = 32'd0; mem_wr = 1'b0; mem_dout = 8'd0;
        tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_din", 32'(mem_din), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("rst_program_stop", 32'(program_stop), 32'h0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        //                a            wr    dout   rxv   rxd    txr  cd    ed     ct  etv  etd
        vecs.push_back(mk(32'h00030005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h0001FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000124, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h0001FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000124, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00030000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48));
        vecs.push_back(mk(32'h00030000, 1'b1, 8'h69, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48));
        vecs.push_back(mk(32'h00030000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48));
        vecs.push_back(mk(32'h00030008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h48));
        vecs.push_back(mk(32'h00030010, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48));
        vecs.push_back(mk(32'h00000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h69));
        vecs.push_back(mk(32'h00000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00000000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00030000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00030000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00030000, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00030000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h0003FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00020005, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(32'h00020005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            tx_ready = vecs[i].txr;
            step(vecs[i].a, vecs[i].wr, vecs[i].dout);
            if (vecs[i].chk_din)
                check($sformatf("vec%0d_din", i), 32'(mem_din), 32'(vecs[i].exp_din));
            if (vecs[i].chk_tx) begin
                check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_txv));
                if (vecs[i].exp_txv)
                    check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_txd));
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // ---------------- TX nearly-full and overflow ----------------
        check("ibf_empty", 32'(io_buffer_full), 32'h0);
        for (int i = 1; i <= 13; i++) step(32'h00030000, 1'b1, 8'(i));
        step(32'h0, 1'b0, 8'h00);
        check("ibf_at_13", 32'(io_buffer_full), 32'h0);
        step(32'h00030000, 1'b1, 8'd14);
        step(32'h0, 1'b0, 8'h00);
        check("ibf_at_14", 32'(io_buffer_full), 32'h1);
        for (int i = 15; i <= 17; i++) step(32'h00030000, 1'b1, 8'(i));
        step(32'h0, 1'b0, 8'h00);
        check("ibf_at_16", 32'(io_buffer_full), 32'h1);
        tx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(tx_valid), 32'h1);
            check($sformatf("drain%0d_data", k), 32'(tx_data), 32'(k));
            step(32'h0, 1'b0, 8'h00);
        end
        check("drain_17th_dropped", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // ---------------- cycle counter snapshot ----------------
        guard = 0;
        while ((edges != 32'd1020) && (guard < 3000)) begin
            step(32'h0, 1'b0, 8'h00);
            guard++;
        end
        check("cnt_reach_1020", edges, 32'd1020);
        exp_cnt = edges;
        step(32'h00030004, 1'b0, 8'h00);
        b0 = mem_din;
        check("cnt_byte0", 32'(b0), 32'(exp_cnt[7:0]));
        repeat (10) step(32'h0, 1'b0, 8'h00);
        step(32'h00030005, 1'b0, 8'h00);
        b1 = mem_din;
        check("cnt_byte1_snap", 32'(b1), 32'(exp_cnt[15:8]));
        step(32'h00030006, 1'b0, 8'h00);
        b2 = mem_din;
        step(32'h00030007, 1'b0, 8'h00);
        b3 = mem_din;
        check("cnt_dword", {b3, b2, b1, b0}, exp_cnt);

        // ---------------- program stop ----------------
        step(32'h00030004, 1'b1, 8'hFF);
        frozen = edges;
        check("stop_flag", 32'(program_stop), 32'h1);
        check("stop_tx_valid", 32'(tx_valid), 32'h1);
        check("stop_tx_zero", 32'(tx_data), 32'h0);
        repeat (3) step(32'h0, 1'b0, 8'h00);
        step(32'h00030004, 1'b0, 8'h00);
        check("frozen_byte0", 32'(mem_din), 32'(frozen[7:0]));
        step(32'h00030005, 1'b0, 8'h00);
        check("frozen_byte1", 32'(mem_din), 32'(frozen[15:8]));
        step(32'h00030004, 1'b1, 8'h00);
        tx_ready = 1'b1;
        step(32'h0, 1'b0, 8'h00);
        check("stop_single_zero", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // ---------------- asynchronous reset mid-transfer ----------------
        step(32'h00030000, 1'b1, 8'h5A);
        step(32'h00000123, 1'b0, 8'h00);
        check("pre_rst_din", 32'(mem_din), 32'hA5);
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_din", 32'(mem_din), 32'h0);
        check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("async_rst_stop", 32'(program_stop), 32'h0);
        check("async_rst_ibf", 32'(io_buffer_full), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step(32'h0, 1'b0, 8'h00);
        exp_cnt = edges;
        step(32'h00030004, 1'b0, 8'h00);
        check("post_rst_cnt", 32'(mem_din), 32'(exp_cnt[7:0]));
        check("post_rst_tx_lost", 32'(tx_valid), 32'h0);
        step(32'h00000123, 1'b0, 8'h00);
        check("post_rst_ram_kept", 32'(mem_din), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
